// File: rtl/sync_ram_pkg.sv
// Shared constants and the byte-enable merge used by sync_ram_dp.
// The merge helper works on the widest supported word; callers size-cast in and out.
package sync_ram_pkg;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    localparam int MAX_BYTES = 8;
    localparam int MAX_W     = 8 * MAX_BYTES;

    function automatic logic [MAX_W-1:0] merge_bytes(
        input logic [MAX_W-1:0]     old_word,
        input logic [MAX_W-1:0]     new_word,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_W-1:0] result;
        for (int i = 0; i < MAX_BYTES; i++) begin
            result[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_ram_rd_pipe.sv
// Read-side output pipeline for sync_ram_dp: one or two register stages of valid/data.
// Parity error side-band is carried only when SYNC_RAM_PARITY_EN is defined.
module sync_ram_rd_pipe #(
    parameter int RD_LAT = 1,
    parameter int W      = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
`ifdef SYNC_RAM_PARITY_EN
    input  logic         par_err_i,
    output logic         par_err_o,
`endif
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         s1_valid_q;
    logic [W-1:0] s1_data_q;
    logic [W-1:0] s1_data_d;

    // Data is forced to zero on idle cycles so the output reads zero whenever valid is low.
    assign s1_data_d = valid_i ? data_i : '0;

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= valid_i;
            s1_data_q  <= s1_data_d;
        end
    end

`ifdef SYNC_RAM_PARITY_EN
    logic s1_par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_par_q <= 1'b0;
        end else begin
            s1_par_q <= valid_i && par_err_i;
        end
    end
`endif

    if (RD_LAT == 2) begin : g_lat2
        logic         s2_valid_q;
        logic [W-1:0] s2_data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_data_q  <= s1_data_q;
            end
        end

        assign valid_o = s2_valid_q;
        assign data_o  = s2_data_q;

`ifdef SYNC_RAM_PARITY_EN
        logic s2_par_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_par_q <= 1'b0;
            end else begin
                s2_par_q <= s1_par_q;
            end
        end

        assign par_err_o = s2_par_q;
`endif
    end else begin : g_lat1
        assign valid_o = s1_valid_q;
        assign data_o  = s1_data_q;
`ifdef SYNC_RAM_PARITY_EN
        assign par_err_o = s1_par_q;
`endif
    end

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("sync_ram_rd_pipe: RD_LAT must be 1 or 2, got %0d", RD_LAT);
    end

endmodule

// File: rtl/sync_ram_dp.sv
// Synchronous one-write/one-read RAM with byte enables, collision policy and range-error tracking.
// Define SYNC_RAM_PARITY_EN to add per-byte even parity with par_err/par_inj ports.
module sync_ram_dp #(
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter int BYTES    = 1,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_en,
    input  logic [ADDR_W-1:0]                   wr_addr,
    input  logic [BYTES-1:0]                    wr_be,
    input  logic [8*BYTES-1:0]                  wr_data,
    input  logic                                rd_en,
    input  logic [ADDR_W-1:0]                   rd_addr,
    output logic                                rd_valid,
    output logic [8*BYTES-1:0]                  rd_data,
    output logic                                err_range,
    input  logic                                clr_err,
`ifdef SYNC_RAM_PARITY_EN
    input  logic                                par_inj,
    output logic                                par_err,
`endif
    output logic [sync_ram_pkg::ERR_CNT_W-1:0]  err_cnt
);

    import sync_ram_pkg::*;

    localparam int                WORD_W  = 8 * BYTES;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_do;
    logic              collide;
    logic              bypass;
    logic [WORD_W-1:0] wr_merged;
    logic [WORD_W-1:0] rd_word;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;
    assign wr_do       = wr_en && wr_in_range && (wr_be != '0);
    assign collide     = wr_do && (wr_addr == rd_addr);
    assign bypass      = (WR_FIRST == sync_ram_pkg::WR_FIRST) && collide;

    // The same merged word feeds the array and, on a write-first collision, the read path.
    assign wr_merged = WORD_W'(merge_bytes(MAX_W'(mem_q[wr_addr]), MAX_W'(wr_data),
                                           MAX_BYTES'(wr_be)));

    // NOTE: the storage array has no reset; clearing it would cost a per-word reset mux and RAMs hold contents anyway.
    always_ff @(posedge clk) begin
        if (wr_do) begin
            mem_q[wr_addr] <= wr_merged;
        end
    end

    // NOTE: a default assignment first means every path drives rd_word, so no latch is inferred.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = bypass ? wr_merged : mem_q[rd_addr];
        end
    end

`ifdef SYNC_RAM_PARITY_EN
    logic [BYTES-1:0] par_mem_q [DEPTH];
    logic [BYTES-1:0] wr_par;
    logic [BYTES-1:0] wr_par_merged;
    logic [BYTES-1:0] rd_par;
    logic             rd_par_err;

    always_comb begin
        for (int i = 0; i < BYTES; i++) begin
            wr_par[i]        = (^wr_data[8*i +: 8]) ^ ((i == 0) && par_inj);
            wr_par_merged[i] = wr_be[i] ? wr_par[i] : par_mem_q[wr_addr][i];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_do) begin
            par_mem_q[wr_addr] <= wr_par_merged;
        end
    end

    always_comb begin
        rd_par     = bypass ? wr_par_merged : par_mem_q[rd_addr];
        rd_par_err = 1'b0;
        for (int i = 0; i < BYTES; i++) begin
            rd_par_err = rd_par_err | ((^rd_word[8*i +: 8]) != rd_par[i]);
        end
        if (!rd_in_range) begin
            rd_par_err = 1'b0;
        end
    end
`endif

    sync_ram_rd_pipe #(
        .RD_LAT (RD_LAT),
        .W      (WORD_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (rd_en),
        .data_i    (rd_word),
`ifdef SYNC_RAM_PARITY_EN
        .par_err_i (rd_par_err),
        .par_err_o (par_err),
`endif
        .valid_o   (rd_valid),
        .data_o    (rd_data)
    );

    logic [1:0]             err_inc;
    logic [ERR_CNT_W:0]     err_sum;
    logic [ERR_CNT_W-1:0]   err_cnt_q;
    logic [ERR_CNT_W-1:0]   err_cnt_d;
    logic                   err_range_q;
    logic                   err_range_d;

    // Each out-of-range port counts once per cycle, so two offending ports add 2.
    assign err_inc = 2'(wr_en && !wr_in_range) + 2'(rd_en && !rd_in_range);
    assign err_sum = {1'b0, err_cnt_q} + (ERR_CNT_W + 1)'(err_inc);

    always_comb begin
        err_cnt_d   = err_cnt_q;
        err_range_d = err_range_q;
        if (clr_err) begin
            err_cnt_d   = '0;
            err_range_d = 1'b0;
        end else if (err_inc != 2'd0) begin
            err_range_d = 1'b1;
            err_cnt_d   = (err_sum > {1'b0, ERR_CNT_MAX}) ? ERR_CNT_MAX : err_sum[ERR_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q   <= '0;
            err_range_q <= 1'b0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            err_range_q <= err_range_d;
        end
    end

    assign err_cnt   = err_cnt_q;
    assign err_range = err_range_q;

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("sync_ram_dp: DEPTH %0d does not fit ADDR_W %0d", DEPTH, ADDR_W);
    end
    if (BYTES < 1 || BYTES > MAX_BYTES) begin : g_bad_bytes
        $error("sync_ram_dp: BYTES must be 1..%0d, got %0d", MAX_BYTES, BYTES);
    end
    if (WR_FIRST != RD_FIRST && WR_FIRST != sync_ram_pkg::WR_FIRST) begin : g_bad_policy
        $error("sync_ram_dp: WR_FIRST must be 0 or 1, got %0d", WR_FIRST);
    end

endmodule

// File: tb/tb_sync_ram_dp.sv
// Scoreboard bench for sync_ram_dp: two instances (latency 1 read-first, latency 2 write-first)
// share one stimulus stream; a behavioural memory model predicts every read and error count.
module tb_sync_ram_dp;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 12;
    localparam int BYTES  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en, rd_en, clr_err, par_inj;
    logic [3:0]  wr_addr, rd_addr;
    logic [1:0]  wr_be;
    logic [15:0] wr_data;

    logic        rd_valid_a, rd_valid_b, err_range_a, err_range_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic [7:0]  err_cnt_a, err_cnt_b;
`ifdef SYNC_RAM_PARITY_EN
    logic        par_err_a, par_err_b;
`endif

    sync_ram_dp #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BYTES(BYTES), .RD_LAT(1), .WR_FIRST(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_a),
        .rd_data(rd_data_a), .err_range(err_range_a), .clr_err(clr_err),
`ifdef SYNC_RAM_PARITY_EN
        .par_inj(par_inj), .par_err(par_err_a),
`endif
        .err_cnt(err_cnt_a)
    );

    sync_ram_dp #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BYTES(BYTES), .RD_LAT(2), .WR_FIRST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_b),
        .rd_data(rd_data_b), .err_range(err_range_b), .clr_err(clr_err),
`ifdef SYNC_RAM_PARITY_EN
        .par_inj(par_inj), .par_err(par_err_b),
`endif
        .err_cnt(err_cnt_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic        par;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [15:0] mem_m  [16];
    bit          bad0_m [16];
    int          err_cnt_m = 0, err_cnt_exp = 0;
    bit          err_range_m = 0, err_range_exp = 0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_idle();
        wr_en = 1'b0; wr_addr = 4'd0; wr_be = 2'b00; wr_data = 16'h0;
        rd_en = 1'b0; rd_addr = 4'd0; clr_err = 1'b0; par_inj = 1'b0;
    endtask

    // Predict the cycle's outcome from the current inputs, then let the edge happen.
    task automatic step();
        int          wa = int'(wr_addr);
        int          ra = int'(rd_addr);
        bit          wr_ok = wr_en && (wa < DEPTH);
        bit          rd_ok = rd_en && (ra < DEPTH);
        bit          hit;
        logic [15:0] new_w;
        bit          new_bad;
        int          n_bad;
        exp_t        ea, eb;

        new_w = mem_m[wr_addr];
        for (int i = 0; i < BYTES; i++) begin
            if (wr_be[i]) new_w[8*i +: 8] = wr_data[8*i +: 8];
        end
        new_bad = wr_be[0] ? bit'(par_inj) : bad0_m[wr_addr];

        if (rd_en) begin
            ea.due = cyc + 1;
            eb.due = cyc + 2;
            if (rd_ok) begin
                hit     = wr_ok && (wa == ra);
                ea.data = mem_m[rd_addr];
                ea.par  = bad0_m[rd_addr];
                eb.data = hit ? new_w : mem_m[rd_addr];
                eb.par  = hit ? new_bad : bad0_m[rd_addr];
            end else begin
                ea.data = 16'h0; ea.par = 1'b0;
                eb.data = 16'h0; eb.par = 1'b0;
            end
            q_a.push_back(ea);
            q_b.push_back(eb);
        end

        if (wr_ok) begin
            mem_m[wr_addr]  = new_w;
            bad0_m[wr_addr] = new_bad;
        end

        n_bad = int'(wr_en && (wa >= DEPTH)) + int'(rd_en && (ra >= DEPTH));
        if (clr_err) begin
            err_cnt_m   = 0;
            err_range_m = 1'b0;
        end else if (n_bad > 0) begin
            err_range_m = 1'b1;
            err_cnt_m   = (err_cnt_m + n_bad > 255) ? 255 : err_cnt_m + n_bad;
        end

        @(posedge clk);
        #1;
        err_cnt_exp   = err_cnt_m;
        err_range_exp = err_range_m;
    endtask

    task automatic drive(input bit wen, input logic [3:0] wa, input logic [1:0] be,
                         input logic [15:0] wd, input bit ren, input logic [3:0] ra,
                         input bit clr, input bit inj);
        wr_en = wen; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = ren; rd_addr = ra; clr_err = clr; par_inj = inj;
        step();
    endtask

    task automatic idle(input int n);
        set_idle();
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        set_idle();
        rst_n = 1'b0;
        q_a.delete();
        q_b.delete();
        err_cnt_m = 0; err_range_m = 1'b0; err_cnt_exp = 0; err_range_exp = 1'b0;
        #1;
        check("rst_valid_a", 32'(rd_valid_a), 32'd0);
        check("rst_valid_b", 32'(rd_valid_b), 32'd0);
        check("rst_data_a",  32'(rd_data_a),  32'd0);
        check("rst_data_b",  32'(rd_data_b),  32'd0);
        check("rst_err_a",   32'(err_cnt_a),  32'd0);
        check("rst_err_b",   32'(err_range_b), 32'd0);
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every read result must appear exactly on its due cycle, in order.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   due_a, due_b;
        due_a = (q_a.size() != 0) && (q_a[0].due == cyc);
        due_b = (q_b.size() != 0) && (q_b[0].due == cyc);
        check("a_rd_valid", 32'(rd_valid_a), 32'(due_a));
        check("b_rd_valid", 32'(rd_valid_b), 32'(due_b));
        if (due_a) begin
            e = q_a.pop_front();
            check("a_rd_data", 32'(rd_data_a), 32'(e.data));
`ifdef SYNC_RAM_PARITY_EN
            check("a_par_err", 32'(par_err_a), 32'(e.par));
`endif
        end else begin
            check("a_idle_data", 32'(rd_data_a), 32'd0);
        end
        if (due_b) begin
            e = q_b.pop_front();
            check("b_rd_data", 32'(rd_data_b), 32'(e.data));
`ifdef SYNC_RAM_PARITY_EN
            check("b_par_err", 32'(par_err_b), 32'(e.par));
`endif
        end else begin
            check("b_idle_data", 32'(rd_data_b), 32'd0);
        end
        check("a_err_range", 32'(err_range_a), 32'(err_range_exp));
        check("b_err_range", 32'(err_range_b), 32'(err_range_exp));
        check("a_err_cnt",   32'(err_cnt_a),   32'(err_cnt_exp));
        check("b_err_cnt",   32'(err_cnt_b),   32'(err_cnt_exp));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          wen, ren;
        logic [3:0]  wa, ra;

        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init_valid_a", 32'(rd_valid_a),  32'd0);
        check("init_valid_b", 32'(rd_valid_b),  32'd0);
        check("init_data_a",  32'(rd_data_a),   32'd0);
        check("init_range_a", 32'(err_range_a), 32'd0);
        check("init_cnt_b",   32'(err_cnt_b),   32'd0);
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) drive(1'b1, 4'(a), 2'b11, 16'($urandom), 1'b0, 4'd0, 1'b0, 1'b0);

        drive(1'b1, 4'd3, 2'b11, 16'hA5C3, 1'b0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 2'b00, 16'h0,    1'b1, 4'd3, 1'b0, 1'b0);
        drive(1'b1, 4'd3, 2'b01, 16'h1234, 1'b0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 2'b00, 16'h0,    1'b1, 4'd3, 1'b0, 1'b0);

        drive(1'b1, 4'd5, 2'b11, 16'h0011, 1'b0, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd5, 2'b11, 16'h00FF, 1'b1, 4'd5, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 2'b00, 16'h0,    1'b1, 4'd5, 1'b0, 1'b0);

        drive(1'b1, 4'd13, 2'b11, 16'hBEEF, 1'b0, 4'd0,  1'b0, 1'b0);
        drive(1'b0, 4'd0,  2'b00, 16'h0,    1'b1, 4'd14, 1'b0, 1'b0);
        idle(3);
        drive(1'b0, 4'd0,  2'b00, 16'h0,    1'b0, 4'd0,  1'b1, 1'b0);
        idle(2);

        drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd1, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd2, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd3, 1'b0, 1'b0);
        idle(3);

        drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd4, 1'b0, 1'b0);
        do_reset(2);
        idle(4);

        drive(1'b1, 4'd0, 2'b11, 16'h5A5A, 1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 2'b00, 16'h0,    1'b1, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd0, 2'b11, 16'h0F0F, 1'b0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 2'b00, 16'h0,    1'b1, 4'd0, 1'b0, 1'b0);
        idle(2);

        repeat (130) drive(1'b1, 4'd15, 2'b11, 16'hFFFF, 1'b1, 4'd12, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 4'd13, 2'b11, 16'h0, 1'b1, 4'd14, 1'b1, 1'b0);
        idle(2);

        repeat (400) begin
            wen = bit'($urandom_range(0, 1));
            ren = bit'($urandom_range(0, 1));
            wa  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
            ra  = ($urandom_range(0, 3) == 0) ? wa :
                  (($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11)));
            drive(wen, wa, 2'($urandom_range(0, 3)), 16'($urandom), ren, ra,
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_ram_dp.md
Name: sync_ram_dp

Overview:
- Parametrised successor to the team's asynchronous single-port RAM model: a synchronous, single-clock, one-write/one-read-port RAM.
- Adds byte enables, configurable read latency, same-address collision policy, out-of-range detection and an operational-error flag.
- Used as the generic on-chip storage primitive for buffers and lookup tables in the block-level flows.

Parameters:
- ADDR_W, 4, address width in bits.
- DEPTH, 16, number of words; must be ≤ 2**ADDR_W; need not be a power of two.
- BYTES, 1, bytes per word; word width = 8*BYTES.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- WR_FIRST, 0, collision policy: 0 = read-first (old data), 1 = write-first (new data).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request this cycle.
- wr_addr  input  ADDR_W  write address.
- wr_be  input  BYTES  per-byte write enable.
- wr_data  input  8*BYTES  write data.
- rd_en  input  1  read request this cycle.
- rd_addr  input  ADDR_W  read address.
- rd_valid  output  1  rd_data valid, RD_LAT cycles after the accepted rd_en.
- rd_data  output  8*BYTES  read data; zero when rd_valid=0.
- err_range  output  1  sticky: an access at address ≥ DEPTH occurred.
- err_cnt  output  8  saturating count of range errors.
- clr_err  input  1  synchronous clear of err_range and err_cnt.

Behaviour:
- Reset (rst_n=0, asynchronous): rd_valid=0, rd_data=0, err_range=0, err_cnt=0, all pipeline valid bits cleared. Memory contents are not reset; they hold prior values and are X in simulation after power-up.
- Write: on a clk edge with wr_en=1 and wr_addr<DEPTH, each byte i with wr_be[i]=1 takes wr_data[8i+7:8i]; other bytes are unchanged. wr_be=0 performs no write.
- Read: rd_en=1 at edge N. With RD_LAT=1, rd_valid=1 and rd_data are registered at edge N+1. With RD_LAT=2, an output register adds one cycle (edge N+2). Back-to-back reads are accepted every cycle at full throughput; there is no backpressure.
- Collision: rd_en and wr_en on the same address in the same cycle.
  - WR_FIRST=0: return the pre-write word.
  - WR_FIRST=1: return the merged word (new bytes where wr_be=1, old bytes otherwise).
- Out of range (addr ≥ DEPTH):
  - Write is dropped.
  - Read returns rd_valid=1 with rd_data=0.
  - err_range is set and err_cnt increments by 1 per offending port per cycle, saturating at 255. A cycle where both ports are out of range adds 2 (saturating).
- clr_err has priority over a same-cycle error increment: the result is 0.
- Reset during an in-flight read: the pending result is discarded; no rd_valid appears after reset is released.
- Illegal RD_LAT: simulation-time $error at elaboration.

Optional Feature:
- Macro SYNC_RAM_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte and written with the data.
  - On read, parity is checked; any mismatch asserts the extra output port par_err (1 bit) aligned with rd_valid. par_err resets to 0.
  - A test-only input par_inj (1 bit) inverts the stored parity of byte 0 on writes.
- When undefined: no parity storage, and neither par_err nor par_inj exists.

Decomposition:
- Package sync_ram_pkg holds:
  - localparams RD_FIRST=0 and WR_FIRST=1;
  - the err_cnt width constant (8) and saturation value (255);
  - a function merging a word with byte enables (shared by the write path and write-first bypass).
- Natural sub-module: sync_ram_rd_pipe, the latency-1/2 output pipeline carrying valid and data (and par_err when enabled), cleared by rst_n.

Test Plan:
- BYTES=2, RD_LAT=1: write 0xA5C3 @3 with be=11, read @3 next cycle → rd_valid one cycle later, rd_data=0xA5C3.
- Byte enable: prior 0xA5C3 @3, write 0x1234 with be=01, read @3 → 0xA534.
- Collision @5, old 0x0011, write 0x00FF be=11 same cycle: WR_FIRST=0 → 0x0011; WR_FIRST=1 → 0x00FF.
- DEPTH=12: write @13 then read @14 → memory unchanged, rd_data=0, err_range=1, err_cnt=2; clr_err → both 0.
- RD_LAT=2, reads @1,@2,@3 on consecutive cycles → rd_valid high for 3 consecutive cycles starting 2 cycles later, data in order. Then assert rst_n=0 with a read in flight → rd_valid=0 immediately and stays 0 after release.
- SYNC_RAM_PARITY_EN: write @0 with par_inj=1, read @0 → par_err=1 with rd_valid. Rewrite with par_inj=0 and read → par_err=0.
